// File: rtl/alarm_timer_pkg.sv
// Shared types and constants for the alarm timer bank.
package alarm_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } timer_state_t;

  // Power-on delays for the four named intervals.
  localparam logic [3:0] ARM_DELAY_DFLT       = 4'd6;
  localparam logic [3:0] DRIVER_DELAY_DFLT    = 4'd8;
  localparam logic [3:0] PASSENGER_DELAY_DFLT = 4'd15;
  localparam logic [3:0] ALARM_ON_DFLT        = 4'd10;

  // Slot indices of the named intervals.
  localparam int unsigned ARM_DELAY_IDX       = 0;
  localparam int unsigned DRIVER_DELAY_IDX    = 1;
  localparam int unsigned PASSENGER_DELAY_IDX = 2;
  localparam int unsigned ALARM_ON_IDX        = 3;

  // Default for one of the named slots; callers handle slots beyond index 3.
  function automatic logic [3:0] named_default(input int unsigned idx);
    case (idx)
      ARM_DELAY_IDX:       named_default = ARM_DELAY_DFLT;
      DRIVER_DELAY_IDX:    named_default = DRIVER_DELAY_DFLT;
      PASSENGER_DELAY_IDX: named_default = PASSENGER_DELAY_DFLT;
      ALARM_ON_IDX:        named_default = ALARM_ON_DFLT;
      default:             named_default = '1;
    endcase
  endfunction

endpackage

// File: rtl/alarm_timer_bank_tick_prescaler.sv
// Free-running tick divider: counts 0..TICK_DIV-1 while enabled, tick on the last count.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // Prescale counter with synchronous clear; holds its value while disabled.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/alarm_timer_bank.sv
// Reprogrammable delay-parameter store with an integrated countdown engine.
// Build option: ALARM_TICK_PRESCALE_EN divides the countdown rate by TICK_DIV.
module alarm_timer_bank
  import alarm_timer_pkg::*;
#(
  parameter int unsigned NUM_PARAMS = 4,
  parameter int unsigned VALUE_W    = 4,
  parameter int unsigned TICK_DIV   = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          reprogram,
  input  logic [$clog2(NUM_PARAMS)-1:0] param_sel,
  input  logic [VALUE_W-1:0]            time_value,
  input  logic [$clog2(NUM_PARAMS)-1:0] interval,
  input  logic                          start_timer,
  input  logic                          abort,
  output logic [VALUE_W-1:0]            value,
  output logic [VALUE_W-1:0]            remaining,
  output logic                          busy,
  output logic                          expired
);

  localparam int unsigned IDX_W = $clog2(NUM_PARAMS);
  localparam logic [IDX_W:0] NUM_P = NUM_PARAMS[IDX_W:0];

  logic [VALUE_W-1:0] slots [NUM_PARAMS];
  timer_state_t       state;
  logic               tick;

`ifdef ALARM_TICK_PRESCALE_EN
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (start_timer || abort),
    .enable (state == COUNT),
    .tick   (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // Parameter slots: named defaults at reset, out-of-range writes dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
        slots[i] <= (i < 4) ? VALUE_W'(named_default(i)) : '1;
      end
    end else if (reprogram && ({1'b0, param_sel} < NUM_P)) begin
      slots[param_sel] <= time_value;
    end
  end

  // Zero-latency read of the selected slot; out-of-range reads as zero.
  always_comb begin
    value = '0;
    if ({1'b0, interval} < NUM_P) begin
      value = slots[interval];
    end
  end

  // Countdown FSM with registered busy/expired; start loads the pre-write slot value.
  always_ff @(posedge clock) begin
    if (reset || abort) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      expired   <= 1'b0;
    end else if (start_timer) begin
      remaining <= value;
      if (value != '0) begin
        state   <= COUNT;
        busy    <= 1'b1;
        expired <= 1'b0;
      end else begin
        state   <= DONE;
        busy    <= 1'b0;
        expired <= 1'b1;
      end
    end else begin
      case (state)
        COUNT: begin
          if (tick) begin
            remaining <= remaining - VALUE_W'(1);
            if (remaining == VALUE_W'(1)) begin
              state   <= DONE;
              busy    <= 1'b0;
              expired <= 1'b1;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          expired <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          expired <= 1'b0;
        end
      endcase
    end
  end

endmodule
